// File: rtl/fsm_b1_pkg.sv
// rtl/fsm_b1_pkg.sv - state type and encodings for the Bresenham stage-1 control FSM
package fsm_b1_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_INT  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    INIT = ST_INIT,
    INT  = ST_INT,
    OUT  = ST_OUT
  } state_t;

  // An interpolator counts as finished if its sticky flag is set or its ack is high now.
  function automatic logic both_done(input logic flag_a, input logic flag_b,
                                     input logic ack_a, input logic ack_b);
    return (flag_a | ack_a) & (flag_b | ack_b);
  endfunction

endpackage

// File: rtl/rise_pulse.sv
// rtl/rise_pulse.sv - registered rising-edge detector producing a one-cycle pulse
module rise_pulse (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic p
);

  logic d_q;
  logic p_q;
  logic p_d;

  assign p_d = d & ~d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      d_q <= d;
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/fsm_b1_ctrl.sv
// rtl/fsm_b1_ctrl.sv - Bresenham stage-1 control FSM; init_br strobe enabled by FSM_B1_INIT_BR_EN
module fsm_b1_ctrl
  import fsm_b1_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_1,
  output logic ack_1,
  output logic req_init,
  input  logic ack_init,
  output logic req_int_a,
  output logic req_int_b,
  input  logic ack_int_a,
  input  logic ack_int_b,
  output logic req_2,
  input  logic ack_2,
  input  logic eoc,
  input  logic req_init_br,
  output logic init_br
);

  state_t state_q;
  state_t state_d;
  logic   done_a_q;
  logic   done_a_d;
  logic   done_b_q;
  logic   done_b_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // eoc overrides every other transition once a line is in progress.
  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && eoc) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_1) state_d = INIT;
        INIT:    if (ack_init) state_d = INT;
        INT:     if (both_done(done_a_q, done_b_q, ack_int_a, ack_int_b)) state_d = OUT;
        OUT:     if (ack_2) state_d = INT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Flags only live while staying in INT, so every entry into INT starts cleared.
  always_comb begin
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    if (state_q == INT && state_d == INT) begin
      done_a_d = done_a_q | ack_int_a;
      done_b_d = done_b_q | ack_int_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
    end else begin
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
    end
  end

  always_comb begin
    ack_1     = 1'b0;
    req_init  = 1'b0;
    req_int_a = 1'b0;
    req_int_b = 1'b0;
    req_2     = 1'b0;
    case (state_q)
      INIT: begin
        ack_1    = 1'b1;
        req_init = 1'b1;
      end
      INT: begin
        req_int_a = 1'b1;
        req_int_b = 1'b1;
      end
      OUT:     req_2 = 1'b1;
      default: ;
    endcase
  end

`ifdef FSM_B1_INIT_BR_EN
  rise_pulse u_init_br (
    .clk (clk),
    .rst (rst),
    .d   (req_init_br),
    .p   (init_br)
  );
`else
  logic unused_req_init_br;
  assign unused_req_init_br = req_init_br;
  assign init_br = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_b1_ctrl.sv
// tb/tb_fsm_b1_ctrl.sv - directed self-checking bench for fsm_b1_ctrl
module tb_fsm_b1_ctrl;

  logic clk;
  logic rst;
  logic req_1;
  logic ack_1;
  logic req_init;
  logic ack_init;
  logic req_int_a;
  logic req_int_b;
  logic ack_int_a;
  logic ack_int_b;
  logic req_2;
  logic ack_2;
  logic eoc;
  logic req_init_br;
  logic init_br;
  logic [4:0] outs;

  int n_cmp;
  int n_bad;

`ifdef FSM_B1_INIT_BR_EN
  localparam logic BR_EN = 1'b1;
`else
  localparam logic BR_EN = 1'b0;
`endif

  // {ack_1, req_init, req_int_a, req_int_b, req_2}
  assign outs = {ack_1, req_init, req_int_a, req_int_b, req_2};

  fsm_b1_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_1       (req_1),
    .ack_1       (ack_1),
    .req_init    (req_init),
    .ack_init    (ack_init),
    .req_int_a   (req_int_a),
    .req_int_b   (req_int_b),
    .ack_int_a   (ack_int_a),
    .ack_int_b   (ack_int_b),
    .req_2       (req_2),
    .ack_2       (ack_2),
    .eoc         (eoc),
    .req_init_br (req_init_br),
    .init_br     (init_br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_1 = 0; ack_init = 0; ack_int_a = 0; ack_int_b = 0;
    ack_2 = 0; eoc = 0; req_init_br = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    tick();
    tick();
    n_cmp++;
    if (outs !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_outs: got %b want %b", outs, 5'b00000);
    end
    n_cmp++;
    if (init_br !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_init_br: got %b want 0", init_br);
    end
    rst = 0;
    tick();
    n_cmp++;
    if (outs !== 5'b00000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b want %b", outs, 5'b00000);
    end
  endtask

  task automatic test_line_start();
    req_1 = 1;
    tick();
    n_cmp++;
    if (outs !== 5'b11000) begin
      n_bad++;
      $display("FAIL start_init: got %b want %b", outs, 5'b11000);
    end
    req_1 = 0;
    tick();
    n_cmp++;
    if (outs !== 5'b11000) begin
      n_bad++;
      $display("FAIL init_hold: got %b want %b", outs, 5'b11000);
    end
    ack_init = 1;
    tick();
    ack_init = 0;
    n_cmp++;
    if (outs !== 5'b00110) begin
      n_bad++;
      $display("FAIL init_to_int: got %b want %b", outs, 5'b00110);
    end
  endtask

  task automatic test_split_acks();
    ack_int_a = 1;
    tick();
    ack_int_a = 0;
    n_cmp++;
    if (outs !== 5'b00110) begin
      n_bad++;
      $display("FAIL split_a_only: got %b want %b", outs, 5'b00110);
    end
    ack_2 = 1;
    tick();
    ack_2 = 0;
    n_cmp++;
    if (outs !== 5'b00110) begin
      n_bad++;
      $display("FAIL ack2_in_int_ignored: got %b want %b", outs, 5'b00110);
    end
    ack_int_b = 1;
    tick();
    ack_int_b = 0;
    n_cmp++;
    if (outs !== 5'b00001) begin
      n_bad++;
      $display("FAIL split_b_to_out: got %b want %b", outs, 5'b00001);
    end
  endtask

  task automatic test_output_loop();
    ack_int_a = 1;
    ack_int_b = 1;
    ack_init  = 1;
    tick();
    ack_int_a = 0;
    ack_int_b = 0;
    ack_init  = 0;
    n_cmp++;
    if (outs !== 5'b00001) begin
      n_bad++;
      $display("FAIL out_ignores_acks: got %b want %b", outs, 5'b00001);
    end
    ack_2 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (outs !== 5'b00110) begin
        n_bad++;
        $display("FAIL out_to_int_cycle%0d: got %b want %b", i, outs, 5'b00110);
      end
    end
    ack_2 = 0;
  endtask

  task automatic test_both_acks();
    ack_int_a = 1;
    ack_int_b = 1;
    tick();
    ack_int_a = 0;
    ack_int_b = 0;
    n_cmp++;
    if (outs !== 5'b00001) begin
      n_bad++;
      $display("FAIL both_acks_to_out: got %b want %b", outs, 5'b00001);
    end
  endtask

  task automatic test_eoc_out();
    eoc = 1;
    tick();
    eoc = 0;
    n_cmp++;
    if (outs !== 5'b00000) begin
      n_bad++;
      $display("FAIL eoc_in_out: got %b want %b", outs, 5'b00000);
    end
    tick();
    n_cmp++;
    if (outs !== 5'b00000) begin
      n_bad++;
      $display("FAIL idle_stays: got %b want %b", outs, 5'b00000);
    end
  endtask

  task automatic test_eoc_int();
    req_1 = 1;
    tick();
    req_1 = 0;
    ack_init = 1;
    tick();
    ack_init = 0;
    ack_int_a = 1;
    ack_int_b = 1;
    eoc = 1;
    tick();
    ack_int_a = 0;
    ack_int_b = 0;
    eoc = 0;
    n_cmp++;
    if (outs !== 5'b00000) begin
      n_bad++;
      $display("FAIL eoc_with_acks_in_int: got %b want %b", outs, 5'b00000);
    end
  endtask

  task automatic test_eoc_init();
    req_1 = 1;
    tick();
    req_1 = 0;
    ack_init = 1;
    eoc = 1;
    tick();
    ack_init = 0;
    eoc = 0;
    n_cmp++;
    if (outs !== 5'b00000) begin
      n_bad++;
      $display("FAIL eoc_with_ack_init: got %b want %b", outs, 5'b00000);
    end
  endtask

  task automatic test_back_to_back();
    req_1 = 1;
    tick();
    eoc = 1;
    tick();
    eoc = 0;
    n_cmp++;
    if (outs !== 5'b00000) begin
      n_bad++;
      $display("FAIL b2b_idle: got %b want %b", outs, 5'b00000);
    end
    tick();
    req_1 = 0;
    n_cmp++;
    if (outs !== 5'b11000) begin
      n_bad++;
      $display("FAIL b2b_restart: got %b want %b", outs, 5'b11000);
    end
    eoc = 1;
    tick();
    eoc = 0;
  endtask

  task automatic test_reset_mid();
    req_1 = 1;
    tick();
    req_1 = 0;
    ack_init = 1;
    tick();
    ack_init = 0;
    ack_int_a = 1;
    ack_int_b = 1;
    tick();
    ack_int_a = 0;
    ack_int_b = 0;
    n_cmp++;
    if (req_2 !== 1'b1) begin
      n_bad++;
      $display("FAIL reach_out: got %b want 1", req_2);
    end
    rst = 1;
    #1;
    n_cmp++;
    if (outs !== 5'b00000) begin
      n_bad++;
      $display("FAIL async_reset_mid_out: got %b want %b", outs, 5'b00000);
    end
    tick();
    rst = 0;
    tick();
    n_cmp++;
    if (outs !== 5'b00000) begin
      n_bad++;
      $display("FAIL idle_after_mid_reset: got %b want %b", outs, 5'b00000);
    end
  endtask

  task automatic test_init_br();
    // First in IDLE, then again while the FSM sits in INT.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        req_1 = 1;
        tick();
        req_1 = 0;
        ack_init = 1;
        tick();
        ack_init = 0;
      end
      req_init_br = 1;
      tick();
      n_cmp++;
      if (init_br !== BR_EN) begin
        n_bad++;
        $display("FAIL init_br_pulse_p%0d: got %b want %b", pass, init_br, BR_EN);
      end
      tick();
      req_init_br = 0;
      n_cmp++;
      if (init_br !== 1'b0) begin
        n_bad++;
        $display("FAIL init_br_single_p%0d: got %b want 0", pass, init_br);
      end
      tick();
      n_cmp++;
      if (init_br !== 1'b0) begin
        n_bad++;
        $display("FAIL init_br_low_p%0d: got %b want 0", pass, init_br);
      end
    end
    n_cmp++;
    if (outs !== 5'b00110) begin
      n_bad++;
      $display("FAIL init_br_state_kept: got %b want %b", outs, 5'b00110);
    end
    eoc = 1;
    tick();
    eoc = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_line_start();
    test_split_acks();
    test_output_loop();
    test_both_acks();
    test_eoc_out();
    test_eoc_int();
    test_eoc_init();
    test_back_to_back();
    test_reset_mid();
    test_init_br();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
